// File: rtl/pio_arbiter_pkg.sv
// Shared types and constants for the PIO arbiter.
// Provides the arbiter FSM state encoding plus the default widths and hold
// length used as parameter defaults by pio_arbiter.
package pio_arbiter_pkg;

  localparam int unsigned DEFAULT_NREQ = 4;
  localparam int unsigned DEFAULT_DW   = 8;
  localparam int unsigned DEFAULT_HOLD = 16;

  // Hold counter width; covers the full legal HOLD_CYCLES range (1..255).
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pio_arbiter_rr_pick.sv
// Combinational round-robin winner search.
// Ports:
//   req    - per-requester request levels
//   rr_ptr - index where the search starts (wraps modulo NREQ)
//   winner - one-hot first requester found at or after rr_ptr; zero if none
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Walk NREQ positions starting at rr_ptr; first set request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = PW'(sum);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_arbiter.sv
// Round-robin arbiter sharing one PIO output port between NREQ requesters.
// A winner's data is registered onto the PIO output and held for at least
// HOLD_CYCLES cycles; the PIO input is brought in through a 2-flop synchronizer.
// Ports:
//   clk_clk      - system clock (rising edge)
//   reset_reset  - asynchronous active-high reset
//   req          - per-requester request level
//   req_data     - packed write data, requester i at [i*DW +: DW]
//   ack          - one-cycle acceptance pulse to the winner
//   grant        - one-hot current owner of the PIO output, zero when idle
//   busy         - high while a granted value is being held
//   pio_out_port - data driven to the PIO
//   pio_in_port  - asynchronous data from the PIO
//   pio_in_sync  - pio_in_port after two flops
module pio_arbiter
  import pio_arbiter_pkg::*;
#(
  parameter int unsigned NREQ        = DEFAULT_NREQ,
  parameter int unsigned DW          = DEFAULT_DW,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [DW-1:0]      pio_out_port,
  input  logic [DW-1:0]      pio_in_port,
  output logic [DW-1:0]      pio_in_sync
);

  localparam int unsigned PW = $clog2(NREQ);

  state_t             state;
  logic [PW-1:0]      rr_ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [NREQ-1:0]    winner;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      next_ptr;
  logic [DW-1:0]      win_data;
  logic [DW-1:0]      sync_q1;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner)
  );

  // One-hot winner to index and data select.
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        win_idx  = PW'(i);
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  // Pointer moves just past the winner, wrapping after the last requester.
  assign next_ptr = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);

  // Arbitration FSM; all outputs registered so req never reaches them combinationally.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      hold_cnt     <= '0;
      pio_out_port <= '0;
      grant        <= '0;
      ack          <= '0;
      busy         <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state        <= HOLD;
            hold_cnt     <= CNT_W'(HOLD_CYCLES - 1);
            pio_out_port <= win_data;
            grant        <= winner;
            ack          <= winner;
            busy         <= 1'b1;
            rr_ptr       <= next_ptr;
          end
        end
        HOLD: begin
          // Requests are ignored here; the hold ends after the counter reads zero.
          if (hold_cnt == '0) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Two-flop synchronizer for the PIO input, independent of arbitration.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_q1     <= '0;
      pio_in_sync <= '0;
    end else begin
      sync_q1     <= pio_in_port;
      pio_in_sync <= sync_q1;
    end
  end

endmodule

// File: tb/tb_pio_arbiter.sv
// Self-checking bench for pio_arbiter: a cycle-level behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_pio_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int HOLD = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic [DW-1:0]       pio_out;
  logic [DW-1:0]       pio_in = '0;
  logic [DW-1:0]       pio_sync;

  int n_checks = 0;
  int n_err    = 0;

  pio_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .grant        (grant),
    .busy         (busy),
    .pio_out_port (pio_out),
    .pio_in_port  (pio_in),
    .pio_in_sync  (pio_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A grant taken at edge g owns the port for outputs after edges g..g+HOLD-1;
  // a new grant is possible at any edge later than g+HOLD.
  int              ecnt = 0;
  int              m_owner = -1;
  int              m_g = 0;
  int              m_ptr = 0;
  logic [DW-1:0]   m_data = '0;
  logic [DW-1:0]   m_s1 = '0;
  logic [DW-1:0]   m_s2 = '0;
  logic [NREQ-1:0] s_req;
  logic [NREQ*DW-1:0] s_data;
  logic [DW-1:0]   s_pin;
  logic            holding;
  logic [NREQ-1:0] e_grant;
  logic [NREQ-1:0] e_ack;
  bit              found;

  always @(posedge clk) begin
    ecnt++;
    s_req  = req;
    s_data = req_data;
    s_pin  = pio_in;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_data  = '0;
      m_s1    = '0;
      m_s2    = '0;
    end else begin
      m_s2 = m_s1;
      m_s1 = s_pin;
      if ((m_owner < 0 || ecnt > m_g + HOLD) && s_req != '0) begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (!found && s_req[i]) begin
            found   = 1;
            m_owner = i;
            m_g     = ecnt;
            m_ptr   = (i + 1) % NREQ;
            m_data  = s_data[i*DW +: DW];
          end
        end
      end
      #1;
      holding = (m_owner >= 0) && (ecnt < m_g + HOLD);
      e_grant = holding ? (NREQ'(1) << m_owner) : '0;
      e_ack   = (holding && ecnt == m_g) ? e_grant : '0;
      chk("model_grant", 32'(grant), 32'(e_grant));
      chk("model_ack", 32'(ack), 32'(e_ack));
      chk("model_busy", 32'(busy), 32'(holding));
      chk("model_pio_out", 32'(pio_out), 32'(m_data));
      chk("model_pio_sync", 32'(pio_sync), 32'(m_s2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ack(input int maxc, output int idx, output int at);
    idx = -1;
    at  = -1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
        at = ecnt;
        return;
      end
    end
    n_checks++;
    n_err++;
    $display("FAIL ack_timeout: got no ack within %0d cycles, required an ack", maxc);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  int idx, at, g, r, bcnt;
  int order [5];
  int edges [5];

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pio_out", 32'(pio_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single request
    req = 4'b0010;
    req_data[15:8] = 8'hA5;
    wait_ack(5, idx, at);
    req = '0;
    chk("single_ack", 32'(ack), 32'h2);
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_pio", 32'(pio_out), 32'hA5);
    bcnt = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      bcnt++;
      @(negedge clk);
    end
    chk("single_busy_len", 32'(bcnt), 32'd16);
    chk("single_idle_grant", 32'(grant), 32'd0);
    chk("single_pio_retained", 32'(pio_out), 32'hA5);

    // Fairness from a fresh pointer
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_data = 32'h44332211;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(40, idx, at);
      order[n] = idx;
      edges[n] = at;
      if (idx >= 0) begin
        req[idx] = 1'b0;
        @(negedge clk);
        req[idx] = 1'b1;
      end
    end
    req = '0;
    chk("fair_order0", 32'(order[0]), 32'd0);
    chk("fair_order1", 32'(order[1]), 32'd1);
    chk("fair_order2", 32'(order[2]), 32'd2);
    chk("fair_order3", 32'(order[3]), 32'd3);
    chk("fair_order4", 32'(order[4]), 32'd0);
    for (int n = 1; n < 5; n++) chk("fair_spacing", 32'(edges[n] - edges[n-1]), 32'd17);
    wait_idle();

    // Wrap-around: move pointer to 3, then 3 and 0 both request
    req = 4'b0100;
    wait_ack(5, idx, at);
    req = '0;
    chk("wrap_setup", 32'(idx), 32'd2);
    wait_idle();
    req = 4'b1001;
    wait_ack(5, idx, at);
    chk("wrap_first", 32'(idx), 32'd3);
    req[3] = 1'b0;
    wait_ack(40, idx, at);
    chk("wrap_second", 32'(idx), 32'd0);
    req[0] = 1'b0;
    wait_idle();
    req = 4'b0011;
    wait_ack(5, idx, at);
    chk("wrap_ptr_is_1", 32'(idx), 32'd1);
    req = '0;
    wait_idle();

    // Hold blocking
    req_data = 32'h00770011;
    req = 4'b0001;
    wait_ack(5, idx, at);
    g = at;
    req = '0;
    repeat (5) @(negedge clk);
    req[2] = 1'b1;
    @(negedge clk);
    chk("hold_no_ack", 32'(ack), 32'd0);
    chk("hold_pio_kept", 32'(pio_out), 32'h11);
    wait_ack(40, idx, at);
    req = '0;
    chk("hold_winner", 32'(idx), 32'd2);
    chk("hold_grant_edge", 32'(at - g), 32'd17);
    chk("hold_new_pio", 32'(pio_out), 32'h77);
    wait_idle();

    // Synchronizer latency
    pio_in = 8'h00;
    repeat (3) @(negedge clk);
    pio_in = 8'h3C;
    @(negedge clk);
    chk("sync_one_edge", 32'(pio_sync), 32'h00);
    @(negedge clk);
    chk("sync_two_edges", 32'(pio_sync), 32'h3C);

    // Reset in the middle of a hold (counter reads 5)
    req_data = 32'h0000C35A;
    req = 4'b0001;
    wait_ack(5, idx, at);
    req = '0;
    repeat (10) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    req = 4'b0010;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pio", 32'(pio_out), 32'd0);
    chk("mid_rst_sync", 32'(pio_sync), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_grant_held", 32'(grant), 32'd0);
    rst = 1'b0;
    r = ecnt;
    @(negedge clk);
    chk("mid_rel_ack", 32'(ack), 32'h2);
    chk("mid_rel_grant", 32'(grant), 32'h2);
    chk("mid_rel_pio", 32'(pio_out), 32'hC3);
    chk("mid_rel_edge", 32'(ecnt - r), 32'd1);
    req = '0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required completion before 200000");
    $fatal(1);
  end

endmodule
